// File: rtl/div_sequencer.sv
// Multi-cycle signed DIV sequencer: restoring division on operand magnitudes,
// sign fix-up, and ownership of the HI/LO registers read by MFHI/MFLO.
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             mf_req,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   // Handshake: start is taken on any edge where busy=0; while busy=1 the
   // pipeline is held by stall so a pending start/mf_req waits, never drops.

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_orig_q;
   logic             sign_q_q, sign_r_q, zero_q;

   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   shifted, diff;
   logic             div_zero_in;

   assign dvd_mag     = dividend[WIDTH-1] ? -dividend : dividend;
   assign dvs_mag     = divisor[WIDTH-1]  ? -divisor  : divisor;
   assign div_zero_in = (divisor == '0);

   // One restoring step: bring in the next dividend bit, trial-subtract.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = div_zero_in ? FIX : CALC;
         CALC:    if (cnt_q == LAST) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      stall     = busy & (mf_req | start);
      state_dbg = state_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         dvd_orig_q  <= '0;
         sign_q_q    <= 1'b0;
         sign_r_q    <= 1'b0;
         zero_q      <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= (state_q == FIX);
         case (state_q)
            IDLE: begin
               if (start) begin
                  quo_q       <= dvd_mag;
                  dvs_q       <= dvs_mag;
                  rem_q       <= '0;
                  cnt_q       <= '0;
                  dvd_orig_q  <= dividend;
                  sign_q_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sign_r_q    <= dividend[WIDTH-1];
                  zero_q      <= div_zero_in;
                  div_by_zero <= 1'b0;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + 1'b1;
               if (!diff[WIDTH]) begin
                  rem_q <= diff[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= shifted[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               if (zero_q) begin
                  hi          <= dvd_orig_q;
                  lo          <= '1;
                  div_by_zero <= 1'b1;
               end else begin
                  lo <= sign_q_q ? -quo_q : quo_q;
                  hi <= sign_r_q ? -rem_q : rem_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: signs, divide-by-zero, overflow, stall,
// back-to-back starts and mid-operation reset.
module tb_div_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         mf_req = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, stall, done, div_by_zero;
   logic [W-1:0] hi, lo;
   logic [1:0]   state_dbg;

   int tests_run = 0;
   int tests_failed = 0;

   div_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .mf_req(mf_req), .busy(busy), .stall(stall), .hi(hi), .lo(lo),
      .done(done), .div_by_zero(div_by_zero), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Driver: one-edge start pulse, then wait (bounded) for done; lat counts edges after accept.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 100) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      step();
      step();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
      tests_run++; if (hi !== '0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi); end
      tests_run++; if (lo !== '0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
      tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int lat;
      run_div(32'd100, 32'd7, lat);
      tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 33", lat); end
      tests_run++; if (hi !== 32'd2) begin tests_failed++; $display("FAIL basic_hi: got %h expected 2", hi); end
      tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("FAIL basic_lo: got %h expected e", lo); end
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_with_done: got %b expected 0", busy); end
      step();
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_signs();
      logic [W-1:0] va [3] = '{32'hFFFFFF9C, 32'd100,     32'hFFFFFF9C};
      logic [W-1:0] vb [3] = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9};
      logic [W-1:0] eq [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
      logic [W-1:0] er [3] = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_div(va[i], vb[i], lat);
         tests_run++; if (lo !== eq[i]) begin tests_failed++; $display("FAIL signs_lo[%0d]: got %h expected %h", i, lo, eq[i]); end
         tests_run++; if (hi !== er[i]) begin tests_failed++; $display("FAIL signs_hi[%0d]: got %h expected %h", i, hi, er[i]); end
         step();
      end
   endtask

   task automatic test_div_zero();
      int lat;
      run_div(32'd7, 32'd0, lat);
      tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
      tests_run++; if (hi !== 32'd7) begin tests_failed++; $display("FAIL dbz_hi: got %h expected 7", hi); end
      tests_run++; if (lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
      tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
      step();
      step();
      tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_sticky: got %b expected 1", div_by_zero); end
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
      lat = 0;
      while (!done && lat < 100) begin step(); lat++; end
      tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("FAIL dbz_next_lo: got %h expected e", lo); end
      step();
   endtask

   task automatic test_overflow();
      int lat;
      run_div(32'h80000000, 32'hFFFFFFFF, lat);
      tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
      tests_run++; if (lo !== 32'h80000000) begin tests_failed++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
      tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL ovf_hi: got %h expected 0", hi); end
      step();
   endtask

   // Old HI/LO here are the overflow result: hi=0, lo=0x80000000.
   task automatic test_mf_stall();
      int cyc;
      dividend = 32'd1000;
      divisor  = 32'hFFFFFFFD;
      start    = 1'b1;
      mf_req   = 1'b1;
      #1;
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mf_idle_stall: got %b expected 0", stall); end
      tests_run++; if (lo !== 32'h80000000) begin tests_failed++; $display("FAIL mf_idle_old_lo: got %h expected 80000000", lo); end
      step();
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL mf_stall[%0d]: got %b expected 1", cyc, stall); end
         tests_run++; if (hi !== 32'd0 || lo !== 32'h80000000) begin tests_failed++; $display("FAIL mf_hold[%0d]: got %h/%h expected 0/80000000", cyc, hi, lo); end
         step();
         cyc++;
      end
      tests_run++; if (cyc !== 33) begin tests_failed++; $display("FAIL mf_stall_len: got %0d expected 33", cyc); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mf_release: got %b expected 0", stall); end
      tests_run++; if (hi !== 32'd1) begin tests_failed++; $display("FAIL mf_new_hi: got %h expected 1", hi); end
      tests_run++; if (lo !== 32'hFFFFFEB3) begin tests_failed++; $display("FAIL mf_new_lo: got %h expected fffffeb3", lo); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL mf_done: got %b expected 1", done); end
      mf_req = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int cyc;
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      step();
      dividend = 32'd1000;
      divisor  = 32'hFFFFFFFD;
      cyc = 0;
      while (busy && cyc < 100) begin
         tests_run++; if (stall !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold[%0d]: got stall=%b done=%b expected 1/0", cyc, stall, done); end
         step();
         cyc++;
      end
      tests_run++; if (cyc !== 33) begin tests_failed++; $display("FAIL b2b_first_len: got %0d expected 33", cyc); end
      tests_run++; if (hi !== 32'd2 || lo !== 32'd14) begin tests_failed++; $display("FAIL b2b_first: got %h/%h expected 2/e", hi, lo); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap_stall: got %b expected 0", stall); end
      step();
      start = 1'b0;
      tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done); end
      cyc = 0;
      while (!done && cyc < 100) begin step(); cyc++; end
      tests_run++; if (cyc !== 33) begin tests_failed++; $display("FAIL b2b_second_len: got %0d expected 33", cyc); end
      tests_run++; if (hi !== 32'd1 || lo !== 32'hFFFFFEB3) begin tests_failed++; $display("FAIL b2b_second: got %h/%h expected 1/fffffeb3", hi, lo); end
      step();
   endtask

   task automatic test_reset_mid();
      int lat;
      dividend = 32'd12345;
      divisor  = 32'd10;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      rst = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      tests_run++; if (hi !== '0 || lo !== '0) begin tests_failed++; $display("FAIL rmid_hilo: got %h/%h expected 0/0", hi, lo); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rmid_done: got %b expected 0", done); end
      step();
      rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_quiet[%0d]: got done=%b busy=%b expected 0/0", i, done, busy); end
      end
      run_div(32'd12345, 32'd10, lat);
      tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL rmid_latency: got %0d expected 33", lat); end
      tests_run++; if (hi !== 32'd5 || lo !== 32'd1234) begin tests_failed++; $display("FAIL rmid_result: got %h/%h expected 5/4d2", hi, lo); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_overflow();
      test_mf_stall();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer for the CPU's DIV instruction. Owns the HI/LO registers read by MFHI/MFLO.
- Runs a 32-step restoring division on operand magnitudes, then applies a sign fix-up.
- Drives a stall back to the pipeline when an MFHI, MFLO or new DIV reaches EX while a division is in flight.
- Sits beside the ALU in the EX stage.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  DIV in EX, sampled when not busy
dividend  in  WIDTH  rs value, signed
divisor  in  WIDTH  rt value, signed
mf_req  in  1  MFHI or MFLO in EX this cycle
busy  out  1  division in progress (state != IDLE)
stall  out  1  freeze IF/ID/EX; combinational
hi  out  WIDTH  remainder register
lo  out  WIDTH  quotient register
done  out  1  one-cycle pulse, cycle after HI/LO update
div_by_zero  out  1  sticky flag for the last DIV; cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hi=0, lo=0, done=0, div_by_zero=0; counter=0.
  - Reset mid-operation aborts the division; HI/LO read 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1, latch |dividend|, |divisor|, sign_q=dividend[W-1]^divisor[W-1], sign_r=dividend[W-1]; clear div_by_zero.
  - If divisor!=0: clear partial remainder, counter=0, go to CALC.
  - If divisor==0: go to FIX with the zero flag set.
- CALC:
  - Each edge: shift {rem,quo} left 1, trial-subtract the divisor magnitude; if non-negative, keep the difference and set quo[0]=1.
  - counter increments; after the WIDTH-th step (counter==WIDTH-1), go to FIX.
- FIX (one cycle), on its edge:
  - Normal divide: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
  - Divide-by-zero: hi = original dividend, lo = all ones, div_by_zero=1.
  - Then go to IDLE, and done=1 for the following cycle.
- Latency:
  - Start accepted at edge E0; CALC covers edges E1..E32; HI/LO are written at edge E33; done is high in the cycle after E33.
  - Divide-by-zero: HI/LO written at E1; done high in the cycle after E1.
- Arithmetic: magnitudes are computed as WIDTH-bit two's complement; negations wrap modulo 2^WIDTH.
  - Example: 0x80000000 / -1 gives lo=0x80000000, hi=0.
- stall = busy & (mf_req | start).
  - MFHI/MFLO stalls until the cycle state returns to IDLE, so it reads the updated HI/LO.
  - A DIV arriving while busy is held, not dropped; it is accepted the first cycle busy=0.
- hi/lo hold their values at all times except the FIX edge; no partial results are ever visible.
- start and mf_req in the same IDLE cycle: start is accepted, and MFHI/MFLO reads the old HI/LO that cycle (program-order-correct because MF precedes DIV).
- done and busy are never high together.

Test Plan:
- 100/7: start=1 for one edge → busy for 33 cycles, then hi=2, lo=14, done pulses once, div_by_zero=0.
- -100/7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); 100/-7 → lo=0xFFFFFFF2, hi=2.
- 7/0 → after 2 edges hi=7, lo=0xFFFFFFFF, div_by_zero=1; the next valid DIV clears the flag.
- 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, no hang.
- mf_req=1 held from the cycle after start → stall=1 through cycle E33, stall=0 when busy drops, and hi/lo show the new result at release.
- Back-to-back DIVs (start held high): the second is accepted the first cycle busy=0.
- Reset mid-operation: drop rst at CALC step 10 → immediately busy=0, hi=lo=0, no done pulse; a fresh DIV after release computes correctly.
